altavoz_tone_axil: RTL

- Second-generation speaker ("altavoz") peripheral: AXI4-Lite slave that drives C_NUM_CH square-wave tone outputs.
- Each channel has a programmable half-period and a toggle count, for fixed-length beeps or continuous tones.
- Adds a global enable, a busy status word, a read-only version register, and an optional completion interrupt.
- Sits behind the PS AXI interconnect. Tone outputs go to the speaker pins or the amplifier enables.

---
 rtl/altavoz_tone_axil_if.sv | 39 +++
 rtl/altavoz_tone_axil.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/altavoz_tone_axil_if.sv
// AXI4-Lite slave bundle for the altavoz tone peripheral.
// Carries the five AXI4-Lite channels (AW, W, B, AR, R). PROT signals are
// intentionally absent because the peripheral ignores them.
//   master : bus initiator (interconnect / testbench)
//   slave  : the peripheral
interface altavoz_tone_axil_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/altavoz_tone_axil.sv
// altavoz_tone_axil: AXI4-Lite slave driving C_NUM_CH square-wave tone outputs.
// Each channel has a half-period (ACLK cycles) and a toggle count; a count of
// 32'hFFFF_FFFF runs continuously. A global enable gates every channel.
//
// Ports:
//   aclk    clock, rising edge
//   areset  synchronous active-high reset
//   s_axi   AXI4-Lite slave (altavoz_tone_axil_if.slave)
//   spk     tone outputs, one per channel
//   irq     completion interrupt (constant 0 unless ALTAVOZ_IRQ_EN is defined)
//
// Register map (byte addresses):
//   0x00      CTRL    bit0 GEN
//   0x04      STATUS  [C_NUM_CH-1:0] BUSY (RO), [16+:C_NUM_CH] DONE (W1C)
//   0x08      VERSION C_VERSION (RO, writes return SLVERR)
//   0x10+8i   PERIOD[i]
//   0x14+8i   COUNT[i] (reads return the live remaining count)
//
// Build option: define ALTAVOZ_IRQ_EN to enable DONE flags and the interrupt.
module altavoz_tone_axil #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 6,
    parameter int          C_NUM_CH           = 4,
    parameter logic [31:0] C_VERSION          = 32'h0002_0000
) (
    input  logic                  aclk,
    input  logic                  areset,
    altavoz_tone_axil_if.slave    s_axi,
    output logic [C_NUM_CH-1:0]   spk,
    output logic                  irq
);

    localparam int          IW   = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [31:0] CONT = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------
    // Write address / data capture
    // ------------------------------------------------------------------
    logic [IW-1:0]                 aw_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [3:0]                    wstrb_q;
    logic                          aw_held, w_held;
    logic                          aw_held_nx, w_held_nx;
    logic                          aw_hs, w_hs, do_write;
    logic [31:0]                   wmask;

    assign aw_hs    = s_axi.awvalid & s_axi.awready;
    assign w_hs     = s_axi.wvalid & s_axi.wready;
    assign do_write = aw_held & w_held & ~s_axi.bvalid;

    always_comb begin
        aw_held_nx = aw_held;
        w_held_nx  = w_held;
        if (do_write) begin
            aw_held_nx = 1'b0;
            w_held_nx  = 1'b0;
        end
        if (aw_hs) aw_held_nx = 1'b1;
        if (w_hs)  w_held_nx  = 1'b1;
    end

    always_comb begin
        wmask = '0;
        for (int b = 0; b < 4; b++) begin
            wmask[8*b +: 8] = {8{wstrb_q[b]}};
        end
    end

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [31:0] mask);
        return (old & ~mask) | (data & mask);
    endfunction

    // Write address decode; VERSION and holes are left unselected so that
    // an error response naturally implies no state change.
    logic                wr_ctrl, wr_status, wr_map;
    logic [C_NUM_CH-1:0] wr_period, wr_count;

    always_comb begin
        wr_ctrl   = (aw_idx == IW'(0));
        wr_status = (aw_idx == IW'(1));
        wr_period = '0;
        wr_count  = '0;
        for (int i = 0; i < C_NUM_CH; i++) begin
            wr_period[i] = (aw_idx == IW'(4 + 2*i));
            wr_count[i]  = (aw_idx == IW'(5 + 2*i));
        end
        wr_map = wr_ctrl | wr_status | (|wr_period) | (|wr_count);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= 2'b00;
        end else begin
            aw_held       <= aw_held_nx;
            w_held        <= w_held_nx;
            s_axi.awready <= ~aw_held_nx;
            s_axi.wready  <= ~w_held_nx;
            if (aw_hs) aw_idx <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            if (w_hs) begin
                wdata_q <= s_axi.wdata;
                wstrb_q <= s_axi.wstrb;
            end
            if (do_write) begin
                s_axi.bvalid <= 1'b1;
                s_axi.bresp  <= wr_map ? 2'b00 : 2'b10;
            end else if (s_axi.bvalid && s_axi.bready) begin
                s_axi.bvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tone engines
    // ------------------------------------------------------------------
    logic                gen;
    logic [31:0]         period   [C_NUM_CH];
    logic [31:0]         count    [C_NUM_CH];
    logic [31:0]         cnt      [C_NUM_CH];
    logic [31:0]         count_nx [C_NUM_CH];
    logic [31:0]         cnt_nx   [C_NUM_CH];
    logic [C_NUM_CH-1:0] spk_nx;
    logic [C_NUM_CH-1:0] done_set;
    logic [C_NUM_CH-1:0] busy;
    logic [C_NUM_CH-1:0] done;

    always_comb begin
        count_nx = count;
        cnt_nx   = cnt;
        spk_nx   = spk;
        done_set = '0;
        for (int i = 0; i < C_NUM_CH; i++) begin
            if (!(gen && (period[i] != 32'd0) && (count[i] != 32'd0))) begin
                cnt_nx[i] = '0;
                spk_nx[i] = 1'b0;
            end else if (cnt[i] >= period[i] - 32'd1) begin
                cnt_nx[i] = '0;
                spk_nx[i] = ~spk[i];
                if (count[i] != CONT) begin
                    count_nx[i] = count[i] - 32'd1;
                    // Final toggle: output parks low and the channel completes.
                    if (count[i] == 32'd1) begin
                        spk_nx[i]   = 1'b0;
                        done_set[i] = 1'b1;
                    end
                end
            end else begin
                cnt_nx[i] = cnt[i] + 32'd1;
            end
            // A bus write to COUNT overrides a same-cycle decrement and never
            // counts as a completion.
            if (do_write && wr_count[i]) begin
                count_nx[i] = merge_bytes(count[i], wdata_q, wmask);
                done_set[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            gen <= 1'b0;
            spk <= '0;
            for (int i = 0; i < C_NUM_CH; i++) begin
                period[i] <= '0;
                count[i]  <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            if (do_write && wr_ctrl && wstrb_q[0]) gen <= wdata_q[0];
            spk <= spk_nx;
            for (int i = 0; i < C_NUM_CH; i++) begin
                count[i] <= count_nx[i];
                cnt[i]   <= cnt_nx[i];
                if (do_write && wr_period[i]) begin
                    period[i] <= merge_bytes(period[i], wdata_q, wmask);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < C_NUM_CH; i++) begin
            busy[i] = (count[i] != 32'd0);
        end
    end

`ifdef ALTAVOZ_IRQ_EN
    logic [C_NUM_CH-1:0] w1c;

    always_comb begin
        w1c = '0;
        if (do_write && wr_status) w1c = wdata_q[16 +: C_NUM_CH] & wmask[16 +: C_NUM_CH];
    end

    // A completion in the same cycle as its W1C keeps the flag set.
    always_ff @(posedge aclk) begin
        if (areset) begin
            done <= '0;
            irq  <= 1'b0;
        end else begin
            done <= (done & ~w1c) | done_set;
            irq  <= |done;
        end
    end
`else
    logic unused_done;
    assign unused_done = ^done_set;
    assign done        = '0;
    assign irq         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic [IW-1:0] ar_idx;
    logic [31:0]   rd_word;
    logic [31:0]   status_word;
    logic          rd_err;
    logic          ar_hs, rvalid_nx;
    logic          unused_addr;

    assign unused_addr = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};
    assign ar_idx      = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_hs       = s_axi.arvalid & s_axi.arready;

    always_comb begin
        status_word                  = '0;
        status_word[C_NUM_CH-1:0]    = busy;
        status_word[16 +: C_NUM_CH]  = done;
    end

    always_comb begin
        rd_word = '0;
        rd_err  = 1'b1;
        if (ar_idx == IW'(0)) begin
            rd_word = {31'd0, gen};
            rd_err  = 1'b0;
        end
        if (ar_idx == IW'(1)) begin
            rd_word = status_word;
            rd_err  = 1'b0;
        end
        if (ar_idx == IW'(2)) begin
            rd_word = C_VERSION;
            rd_err  = 1'b0;
        end
        for (int i = 0; i < C_NUM_CH; i++) begin
            if (ar_idx == IW'(4 + 2*i)) begin
                rd_word = period[i];
                rd_err  = 1'b0;
            end
            if (ar_idx == IW'(5 + 2*i)) begin
                rd_word = count[i];
                rd_err  = 1'b0;
            end
        end
    end

    always_comb begin
        rvalid_nx = s_axi.rvalid;
        if (ar_hs) rvalid_nx = 1'b1;
        else if (s_axi.rvalid && s_axi.rready) rvalid_nx = 1'b0;
    end

    // Read data is sampled from the pre-edge register state, so a write
    // completing on the same edge is not visible to this read.
    always_ff @(posedge aclk) begin
        if (areset) begin
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= 2'b00;
        end else begin
            s_axi.rvalid  <= rvalid_nx;
            s_axi.arready <= ~rvalid_nx;
            if (ar_hs) begin
                s_axi.rdata <= rd_err ? 32'd0 : rd_word;
                s_axi.rresp <= rd_err ? 2'b10 : 2'b00;
            end
        end
    end

endmodule
